exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. Consumes the registered outputs of the ID/EX pipeline register and applies forwarding to its operands. Computes Val2 (immediate rotate / register shift / memory offset), runs the ALU and holds the NZCV status register. Produces the branch target for the fetch stage and a registered EX/MEM bundle for the memory stage.

---
 rtl/exe_stage.sv | 190 +++++++++++++++++++
 tb/tb_exe_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline.
// Forwards operands, builds Val2 (rotated immediate, shifted register or memory
// offset), runs the ALU, holds the NZCV status register and drives the EX/MEM
// register. The branch target is produced combinationally for fetch.
module exe_stage #(
    parameter int ADDRESS_LEN = 32,
    parameter int DATA_LEN    = 32,
    parameter int CMD_LEN     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic                   b_in,
    input  logic                   s_in,
    input  logic                   imm_in,
    input  logic [CMD_LEN-1:0]     exec_cmd_in,
    input  logic [ADDRESS_LEN-1:0] pc_in,
    input  logic [DATA_LEN-1:0]    val_r_n_in,
    input  logic [DATA_LEN-1:0]    val_r_m_in,
    input  logic [11:0]            shift_operand_in,
    input  logic [23:0]            signed_imm_24_in,
    input  logic [3:0]             dest_in,
    input  logic [1:0]             sel_src1,
    input  logic [1:0]             sel_src2,
    input  logic [DATA_LEN-1:0]    mem_fwd_in,
    input  logic [DATA_LEN-1:0]    wb_fwd_in,
    output logic                   branch_taken_out,
    output logic [ADDRESS_LEN-1:0] branch_addr_out,
    output logic [3:0]             status_out,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic                   mem_w_en_out,
    output logic [DATA_LEN-1:0]    alu_result_out,
    output logic [DATA_LEN-1:0]    store_val_out,
    output logic [3:0]             dest_out
);

    localparam logic [CMD_LEN-1:0] CMD_MOV = 'd1;
    localparam logic [CMD_LEN-1:0] CMD_ADD = 'd2;
    localparam logic [CMD_LEN-1:0] CMD_ADC = 'd3;
    localparam logic [CMD_LEN-1:0] CMD_SUB = 'd4;
    localparam logic [CMD_LEN-1:0] CMD_SBC = 'd5;
    localparam logic [CMD_LEN-1:0] CMD_AND = 'd6;
    localparam logic [CMD_LEN-1:0] CMD_ORR = 'd7;
    localparam logic [CMD_LEN-1:0] CMD_EOR = 'd8;
    localparam logic [CMD_LEN-1:0] CMD_MVN = 'd9;
    localparam int MSB = DATA_LEN - 1;

    // Rotate right; an amount of zero returns the value unchanged.
    function automatic logic [DATA_LEN-1:0] rotate_right(input logic [DATA_LEN-1:0] v,
                                                         input logic [4:0] amt);
        return DATA_LEN'({v, v} >> amt);
    endfunction

    // Register shifter: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
    function automatic logic [DATA_LEN-1:0] shift_rm(input logic [DATA_LEN-1:0] v,
                                                     input logic [1:0] kind,
                                                     input logic [4:0] amt);
        logic signed [DATA_LEN-1:0] sv;
        logic        [DATA_LEN-1:0] res;
        sv = v;
        case (kind)
            2'b00:   res = v << amt;
            2'b01:   res = v >> amt;
            2'b10:   res = sv >>> amt;
            default: res = rotate_right(v, amt);
        endcase
        return res;
    endfunction

    logic [DATA_LEN-1:0]       op_a;
    logic [DATA_LEN-1:0]       op_m;
    logic [DATA_LEN-1:0]       val2;
    logic [DATA_LEN-1:0]       alu_res;
    logic [DATA_LEN:0]         sum;
    logic [3:0]                new_flags;
    logic                      cmd_ok;
    logic signed [ADDRESS_LEN-1:0] br_off;

    logic [3:0]                status_p1;
    logic                      wb_en_p1;
    logic                      mem_r_en_p1;
    logic                      mem_w_en_p1;
    logic [DATA_LEN-1:0]       alu_result_p1;
    logic [DATA_LEN-1:0]       store_val_p1;
    logic [3:0]                dest_p1;

    // Operand forwarding; select 11 falls back to the register file.
    always_comb begin
        case (sel_src1)
            2'b01:   op_a = mem_fwd_in;
            2'b10:   op_a = wb_fwd_in;
            default: op_a = val_r_n_in;
        endcase
        case (sel_src2)
            2'b01:   op_m = mem_fwd_in;
            2'b10:   op_m = wb_fwd_in;
            default: op_m = val_r_m_in;
        endcase
    end

    // Val2: memory offset wins over immediate, immediate over register shift.
    always_comb begin
        if (mem_r_en_in | mem_w_en_in)
            val2 = {{(DATA_LEN-12){1'b0}}, shift_operand_in};
        else if (imm_in)
            val2 = rotate_right({{(DATA_LEN-8){1'b0}}, shift_operand_in[7:0]},
                                {shift_operand_in[11:8], 1'b0});
        else
            val2 = shift_rm(op_m, shift_operand_in[6:5], shift_operand_in[11:7]);
    end

    // ALU and flag generation; C/V default to the held status for logical ops.
    always_comb begin
        alu_res   = '0;
        sum       = '0;
        cmd_ok    = 1'b1;
        new_flags = status_p1;
        case (exec_cmd_in)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = op_a & val2;
            CMD_ORR: alu_res = op_a | val2;
            CMD_EOR: alu_res = op_a ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, op_a} + {1'b0, val2}
                    + {{DATA_LEN{1'b0}}, (exec_cmd_in == CMD_ADC) & status_p1[1]};
                alu_res      = sum[MSB:0];
                new_flags[1] = sum[DATA_LEN];
                new_flags[0] = (op_a[MSB] == val2[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                // A + ~B + 1 for SUB, A + ~B + C for SBC; carry out is NOT borrow.
                sum = {1'b0, op_a} + {1'b0, ~val2}
                    + {{DATA_LEN{1'b0}}, (exec_cmd_in == CMD_SUB) | status_p1[1]};
                alu_res      = sum[MSB:0];
                new_flags[1] = sum[DATA_LEN];
                new_flags[0] = (op_a[MSB] != val2[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            default: cmd_ok = 1'b0;
        endcase
        if (cmd_ok) begin
            new_flags[3] = alu_res[MSB];
            new_flags[2] = (alu_res == '0);
        end
    end

    assign br_off           = {{(ADDRESS_LEN-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
    assign branch_addr_out  = pc_in + br_off;
    assign branch_taken_out = b_in;

    // Stage boundary EX -> status register: loads only for S instructions not frozen.
    always_ff @(posedge clk) begin
        if (rst)
            status_p1 <= '0;
        else if (s_in & ~freeze)
            status_p1 <= new_flags;
    end

    // Stage boundary EX -> MEM: the whole bundle holds while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_p1      <= 1'b0;
            mem_r_en_p1   <= 1'b0;
            mem_w_en_p1   <= 1'b0;
            alu_result_p1 <= '0;
            store_val_p1  <= '0;
            dest_p1       <= '0;
        end else if (~freeze) begin
            wb_en_p1      <= wb_en_in;
            mem_r_en_p1   <= mem_r_en_in;
            mem_w_en_p1   <= mem_w_en_in;
            alu_result_p1 <= alu_res;
            store_val_p1  <= op_m;
            dest_p1       <= dest_in;
        end
    end

    assign status_out     = status_p1;
    assign wb_en_out      = wb_en_p1;
    assign mem_r_en_out   = mem_r_en_p1;
    assign mem_w_en_out   = mem_w_en_p1;
    assign alu_result_out = alu_result_p1;
    assign store_val_out  = store_val_p1;
    assign dest_out       = dest_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed test-plan sequences followed by random traffic.
// A reference model computes expected EX/MEM and status values, a queue carries
// them to a monitor that compares after every rising edge.
module tb_exe_stage;

    typedef struct {
        bit        rst, freeze, wb, mr, mw, b, s, imm;
        bit [3:0]  cmd;
        bit [31:0] pc, rn, rm, mf, wf;
        bit [11:0] so;
        bit [23:0] imm24;
        bit [3:0]  dest;
        bit [1:0]  s1, s2;
    } stim_t;

    typedef struct {
        bit        wb, mr, mw;
        bit [31:0] res, st;
        bit [3:0]  dest, status;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exec_cmd_in, dest_in;
    logic [31:0] pc_in, val_r_n_in, val_r_m_in, mem_fwd_in, wb_fwd_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [1:0]  sel_src1, sel_src2;
    logic        branch_taken_out, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [31:0] branch_addr_out, alu_result_out, store_val_out;
    logic [3:0]  status_out, dest_out;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb_q[$];

    // Reference model state
    exp_t m;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exec_cmd_in(exec_cmd_in),
        .pc_in(pc_in), .val_r_n_in(val_r_n_in), .val_r_m_in(val_r_m_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_in(mem_fwd_in), .wb_fwd_in(wb_fwd_in),
        .branch_taken_out(branch_taken_out), .branch_addr_out(branch_addr_out),
        .status_out(status_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .alu_result_out(alu_result_out),
        .store_val_out(store_val_out), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic longint unsigned rotr(input longint unsigned x, input int r);
        return ((x >> r) | (x << (32 - r))) & 64'hFFFF_FFFF;
    endfunction

    function automatic bit ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Behavioural model of one clock edge given the inputs held across it.
    task automatic model(input stim_t x);
        longint unsigned a, rm, v2, r, full;
        longint          sa, sb, sr;
        bit [31:0]       t;
        int              sm, n;
        bit              c, v, ok, arith, cin;
        if (x.rst) begin
            m = '{default: 0};
            return;
        end
        a  = (x.s1 == 2'd1) ? x.mf : (x.s1 == 2'd2) ? x.wf : x.rn;
        rm = (x.s2 == 2'd1) ? x.mf : (x.s2 == 2'd2) ? x.wf : x.rm;
        if (x.mr || x.mw) v2 = x.so;
        else if (x.imm) v2 = rotr(x.so[7:0], 2 * x.so[11:8]);
        else begin
            n = x.so[11:7];
            case (x.so[6:5])
                2'd0: v2 = (rm << n) & 64'hFFFF_FFFF;
                2'd1: v2 = rm >> n;
                2'd2: begin sm = rm[31:0]; t = sm >>> n; v2 = t; end
                default: v2 = rotr(rm, n);
            endcase
        end
        sa = $signed(a[31:0]);
        sb = $signed(v2[31:0]);
        cin = m.status[1];
        ok = 1; arith = 1; c = 0; v = 0; r = 0;
        case (x.cmd)
            4'd1: begin r = v2; arith = 0; end
            4'd9: begin r = ~v2 & 64'hFFFF_FFFF; arith = 0; end
            4'd6: begin r = a & v2; arith = 0; end
            4'd7: begin r = a | v2; arith = 0; end
            4'd8: begin r = a ^ v2; arith = 0; end
            4'd2: begin full = a + v2; c = full[32]; sr = sa + sb; v = ovf(sr); end
            4'd3: begin full = a + v2 + cin; c = full[32]; sr = sa + sb + cin; v = ovf(sr); end
            4'd4: begin full = a - v2; c = (a >= v2); sr = sa - sb; v = ovf(sr); end
            4'd5: begin
                full = a - v2 - (1 - cin); c = (a >= v2 + (1 - cin));
                sr = sa - sb - (1 - cin); v = ovf(sr);
            end
            default: begin ok = 0; arith = 0; full = 0; end
        endcase
        if (arith) r = full & 64'hFFFF_FFFF;
        if (x.s && !x.freeze && ok)
            m.status = {r[31], r[31:0] == 0, arith ? c : m.status[1], arith ? v : m.status[0]};
        if (!x.freeze) begin
            m.wb = x.wb; m.mr = x.mr; m.mw = x.mw;
            m.res = r[31:0]; m.st = rm[31:0]; m.dest = x.dest;
        end
    endtask

    // Apply one instruction at a falling edge, check branch outputs, queue expectation.
    task automatic drive(input stim_t x);
        bit [31:0] off;
        rst = x.rst; freeze = x.freeze; wb_en_in = x.wb; mem_r_en_in = x.mr;
        mem_w_en_in = x.mw; b_in = x.b; s_in = x.s; imm_in = x.imm;
        exec_cmd_in = x.cmd; pc_in = x.pc; val_r_n_in = x.rn; val_r_m_in = x.rm;
        mem_fwd_in = x.mf; wb_fwd_in = x.wf; shift_operand_in = x.so;
        signed_imm_24_in = x.imm24; dest_in = x.dest; sel_src1 = x.s1; sel_src2 = x.s2;
        #1;
        off = {{8{x.imm24[23]}}, x.imm24};
        chk("branch_taken", {31'b0, branch_taken_out}, {31'b0, x.b});
        chk("branch_addr", branch_addr_out, x.pc + off * 4);
        model(x);
        sb_q.push_back(m);
        @(negedge clk);
    endtask

    function automatic bit [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t x;
        x.rst = ($urandom_range(0, 49) == 0);
        x.freeze = ($urandom_range(0, 4) == 0);
        x.wb = $urandom; x.b = $urandom; x.s = $urandom;
        x.mr = ($urandom_range(0, 7) == 0); x.mw = ($urandom_range(0, 7) == 0);
        x.imm = ($urandom_range(0, 2) == 0);
        x.cmd = $urandom; x.pc = $urandom; x.rn = pick32(); x.rm = pick32();
        x.mf = pick32(); x.wf = pick32(); x.so = $urandom; x.imm24 = $urandom;
        x.dest = $urandom; x.s1 = $urandom; x.s2 = $urandom;
        return x;
    endfunction

    // Monitor: compare the registered bundle after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wb_en",    {31'b0, wb_en_out},    {31'b0, e.wb});
                chk("mem_r_en", {31'b0, mem_r_en_out}, {31'b0, e.mr});
                chk("mem_w_en", {31'b0, mem_w_en_out}, {31'b0, e.mw});
                chk("alu_result", alu_result_out, e.res);
                chk("store_val",  store_val_out,  e.st);
                chk("dest",   {28'b0, dest_out},   {28'b0, e.dest});
                chk("status", {28'b0, status_out}, {28'b0, e.status});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t x, z;
        z = '{default: 0};
        m = '{default: 0};
        rst = 1; freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        b_in = 0; s_in = 0; imm_in = 0; exec_cmd_in = 0; pc_in = 0; val_r_n_in = 0;
        val_r_m_in = 0; mem_fwd_in = 0; wb_fwd_in = 0; shift_operand_in = 0;
        signed_imm_24_in = 0; dest_in = 0; sel_src1 = 0; sel_src2 = 0;
        @(negedge clk);

        x = z; x.rst = 1; drive(x); drive(x);
        chk("reset_status", {28'b0, status_out}, 32'h0);
        chk("reset_result", alu_result_out, 32'h0);

        // ADDS overflow
        x = z; x.rn = 32'h7FFF_FFFF; x.imm = 1; x.so = 12'h001; x.cmd = 4'd2; x.s = 1; x.wb = 1;
        drive(x);
        chk("adds_result", alu_result_out, 32'h8000_0000);
        chk("adds_status", {28'b0, status_out}, 32'h9);

        // SUBS to zero, then ADC consuming C
        x = z; x.rn = 5; x.rm = 5; x.so = 12'h000; x.cmd = 4'd4; x.s = 1;
        drive(x);
        chk("subs_result", alu_result_out, 32'h0);
        chk("subs_status", {28'b0, status_out}, 32'h6);
        x = z; x.rn = 1; x.imm = 1; x.so = 12'h001; x.cmd = 4'd3;
        drive(x);
        chk("adc_result", alu_result_out, 32'h3);

        // Shifter
        x = z; x.rm = 32'h8000_0001; x.cmd = 4'd1;
        x.so = 12'h0C0; drive(x); chk("asr1", alu_result_out, 32'hC000_0000);
        x.so = 12'h260; drive(x); chk("ror4", alu_result_out, 32'h1800_0000);
        x.so = 12'hFA0; drive(x); chk("lsr31", alu_result_out, 32'h0000_0001);
        x.imm = 1; x.so = 12'h4FF; drive(x); chk("imm_rot", alu_result_out, 32'hFF00_0000);

        // Forwarding
        x = z; x.s1 = 2'd1; x.mf = 32'h10; x.s2 = 2'd2; x.wf = 32'h20;
        x.rn = 32'hDEAD_0000; x.rm = 32'h0BAD_0000; x.cmd = 4'd2;
        drive(x);
        chk("fwd_result", alu_result_out, 32'h30);
        chk("fwd_store", store_val_out, 32'h20);

        // Memory offset and branch target
        x = z; x.mr = 1; x.so = 12'hFFC; x.cmd = 4'd1; x.b = 1; x.pc = 32'h100;
        x.imm24 = 24'hFFFFFE; x.dest = 4'd3;
        drive(x);
        chk("mem_offset", alu_result_out, 32'h0000_0FFC);
        chk("branch_const", branch_addr_out, 32'h0000_00F8);

        // Freeze three cycles with S set and changing inputs
        for (int i = 0; i < 3; i++) begin
            x = rand_stim(); x.rst = 0; x.freeze = 1; x.s = 1; x.cmd = 4'd2;
            drive(x);
            chk("frz_result", alu_result_out, 32'h0000_0FFC);
            chk("frz_status", {28'b0, status_out}, 32'h6);
        end

        // Reset after activity
        x = rand_stim(); x.rst = 1; x.freeze = 1; x.s = 1;
        drive(x);
        chk("rst_result", alu_result_out, 32'h0);
        chk("rst_status", {28'b0, status_out}, 32'h0);
        chk("rst_mem_r", {31'b0, mem_r_en_out}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) drive(rand_stim());

        x = z; drive(x);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
